// File: rtl/fir_output_decimator_if.sv
// Sample delivery bus between the FIR back-end and the binary-search controller.
// valid/ready: a sample transfers on a rising CLK_Filter edge where dout_valid & dout_ready;
// dout/sat stay stable while dout_valid is high and dout_ready is low.
interface fir_output_decimator_if;
  logic [19:0] filt_data;
  logic        flush;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        sat;
  logic        overrun;
  logic        clr_ovr;

  modport master (
    input  filt_data, flush, dout_ready, clr_ovr,
    output dout, dout_valid, sat, overrun
  );

  modport slave (
    output filt_data, flush, dout_ready, clr_ovr,
    input  dout, dout_valid, sat, overrun
  );
endinterface

// File: rtl/fir_output_decimator.sv
// FIR back-end: blanks warm-up, decimates, rescales by 1/DC-gain with rounding and
// saturation to 8 bits, and queues results in a 2-entry FIFO for the consumer.
module fir_output_decimator #(
  parameter int WARMUP     = 25,
  parameter int DECIM      = 4,
  parameter int GAIN_MUL   = 189,
  parameter int GAIN_SHIFT = 18
) (
  input  logic                   CLK_Filter,
  input  logic                   rst_n,
  fir_output_decimator_if.master bus
);

  localparam int PROD_W  = 28;
  localparam int WARM_W  = $clog2(WARMUP + 1);
  localparam int DECIM_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP - 1);
  localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);
  localparam logic [PROD_W:0]    RND_HALF   = (PROD_W + 1)'(1) << (GAIN_SHIFT - 1);

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [DECIM_W-1:0]   decim_cnt_q, decim_cnt_d;
  logic                 strobe;

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WARM;
      warm_cnt_q  <= '0;
      decim_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      decim_cnt_q <= decim_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    decim_cnt_d = decim_cnt_q;
    strobe      = 1'b0;
    if (bus.flush) begin
      state_d     = ST_WARM;
      warm_cnt_d  = '0;
      decim_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_WARM: begin
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            state_d     = ST_RUN;
            decim_cnt_d = '0;
          end
        end
        ST_RUN: begin
          strobe = (decim_cnt_q == DECIM_LAST);
          decim_cnt_d = strobe ? '0 : decim_cnt_q + 1'b1;
        end
        default: begin
          state_d     = ST_WARM;
          warm_cnt_d  = '0;
          decim_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rescale pipeline: S1 multiplies on the strobe edge, S2 rounds/saturates
  // combinationally from the product and pushes on the following edge.
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] prod_d;
  logic              v1_q;

  assign prod_d = PROD_W'(bus.filt_data) * PROD_W'(GAIN_MUL);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
    end else if (bus.flush) begin
      v1_q   <= 1'b0;
    end else begin
      v1_q <= strobe;
      if (strobe) prod_q <= prod_d;
    end
  end

  // The rounding sum carries one extra bit so it can never wrap.
  logic [PROD_W:0] rnd_sum;
  logic [PROD_W:0] scaled;
  logic            clip;
  entry_t          new_entry;

  always_comb begin
    rnd_sum        = {1'b0, prod_q} + RND_HALF;
    scaled         = rnd_sum >> GAIN_SHIFT;
    clip           = (scaled > (PROD_W + 1)'(255));
    new_entry.data = clip ? 8'hFF : scaled[7:0];
    new_entry.sat  = clip;
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic [7:0] last_dout_q;
  logic       overrun_q;
  logic       not_empty;
  logic       full;
  logic       push, pop, push_ok, drop;
  entry_t     head;

  assign not_empty = (count_q != 2'd0);
  assign full      = (count_q == 2'd2);
  assign head      = mem_q[rd_ptr_q];
  assign push      = v1_q;
  assign pop       = not_empty & bus.dout_ready;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign push_ok   = push & (!full | pop);
  assign drop      = push & full & !pop;

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (bus.flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Remembers the most recently shown head so dout holds once the FIFO drains.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      last_dout_q <= 8'd0;
    end else if (not_empty) begin
      last_dout_q <= head.data;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (bus.flush) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.dout       = not_empty ? head.data : last_dout_q;
  assign bus.sat        = not_empty & head.sat;
  assign bus.dout_valid = not_empty;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: warm-up timing, rescale table, FIFO
// back-pressure/overrun, push+pop on full, flush and async reset.
module tb_fir_output_decimator;

  logic CLK_Filter;
  logic rst_n;
  fir_output_decimator_if bus ();

  fir_output_decimator dut (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial CLK_Filter = 1'b0;
  always #5 CLK_Filter = ~CLK_Filter;

  int total;
  int bad;
  int edge_n;

  typedef struct {
    logic [19:0] filt;
    logic [7:0]  exp_dout;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [8];

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK_Filter);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int v, input int d, input int s);
    chk({name, "_valid"}, int'(bus.dout_valid), v);
    chk({name, "_dout"},  int'(bus.dout), d);
    chk({name, "_sat"},   int'(bus.sat), s);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int early;
    total  = 0;
    bad    = 0;
    edge_n = 0;

    vecs[0] = '{20'd176715,  8'd127, 1'b0};
    vecs[1] = '{20'd0,       8'd0,   1'b0};
    vecs[2] = '{20'd694,     8'd1,   1'b0};
    vecs[3] = '{20'd693,     8'd0,   1'b0};
    vecs[4] = '{20'd1048575, 8'd255, 1'b1};
    vecs[5] = '{20'd354379,  8'd255, 1'b0};
    vecs[6] = '{20'd354380,  8'd255, 1'b1};
    vecs[7] = '{20'd138600,  8'd100, 1'b0};

    rst_n          = 1'b0;
    bus.filt_data  = 20'd353430;
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b1;
    bus.clr_ovr    = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK_Filter);
    #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_overrun", int'(bus.overrun), 0);
    rst_n  = 1'b1;
    edge_n = 0;

    // T1: warm-up blanking and first sample timing
    early = 0;
    for (int e = 1; e <= 29; e++) begin
      tick();
      if (bus.dout_valid) early++;
    end
    chk("t1_no_early_valid", early, 0);
    tick_to(30);
    chk_out("t1_first", 1, 255, 0);
    tick_to(31);
    chk("t1_popped_valid", int'(bus.dout_valid), 0);
    chk("t1_hold_dout", int'(bus.dout), 255);
    tick_to(33);
    chk("t1_gap_valid", int'(bus.dout_valid), 0);
    tick_to(34);
    chk_out("t1_second", 1, 255, 0);

    // T2/T3: rescale table, one sample per decimation period
    for (int i = 0; i < 8; i++) begin
      tick_to(34 + 4 * i);
      bus.filt_data = vecs[i].filt;
      tick_to(38 + 4 * i);
      chk_out($sformatf("vec%0d", i), 1, int'(vecs[i].exp_dout), int'(vecs[i].exp_sat));
    end

    // T4: back-pressure, third sample dropped, sticky overrun then cleared
    tick_to(67);
    bus.dout_ready = 1'b0;
    bus.filt_data  = 20'd176715;
    tick_to(70);
    chk_out("t4_first", 1, 127, 0);
    bus.filt_data = 20'd694;
    tick_to(74);
    chk_out("t4_held", 1, 127, 0);
    chk("t4_ovr_before", int'(bus.overrun), 0);
    bus.filt_data = 20'd0;
    tick_to(78);
    chk_out("t4_full", 1, 127, 0);
    chk("t4_ovr_set", int'(bus.overrun), 1);
    bus.dout_ready = 1'b1;
    tick_to(79);
    chk_out("t4_second", 1, 1, 0);
    tick_to(80);
    chk("t4_third_dropped", int'(bus.dout_valid), 0);
    chk("t4_ovr_sticky", int'(bus.overrun), 1);
    bus.clr_ovr = 1'b1;
    tick_to(81);
    bus.clr_ovr = 1'b0;
    chk("t4_ovr_cleared", int'(bus.overrun), 0);

    // T5: full FIFO with a pop on the same edge as a push
    bus.dout_ready = 1'b0;
    bus.filt_data  = 20'd176715;
    tick_to(86);
    bus.filt_data = 20'd694;
    tick_to(89);
    bus.dout_ready = 1'b1;
    tick_to(90);
    bus.dout_ready = 1'b0;
    chk_out("t5_head", 1, 127, 0);
    chk("t5_no_ovr", int'(bus.overrun), 0);
    bus.dout_ready = 1'b1;
    tick_to(91);
    chk_out("t5_kept", 1, 1, 0);
    tick_to(92);
    chk("t5_empty", int'(bus.dout_valid), 0);

    // Overrun set wins over a simultaneous clear
    bus.dout_ready = 1'b0;
    tick_to(101);
    bus.clr_ovr = 1'b1;
    tick_to(102);
    bus.clr_ovr = 1'b0;
    chk("set_beats_clr", int'(bus.overrun), 1);

    // T6: flush during RUN with one entry queued
    bus.dout_ready = 1'b1;
    tick_to(103);
    bus.dout_ready = 1'b0;
    chk_out("t6_one_entry", 1, 1, 0);
    bus.flush = 1'b1;
    tick_to(104);
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b1;
    bus.filt_data  = 20'd176715;
    chk_out("t6_flushed", 0, 1, 0);
    chk("t6_ovr_flushed", int'(bus.overrun), 0);
    early = 0;
    for (int e = 105; e <= 133; e++) begin
      tick();
      if (bus.dout_valid) early++;
    end
    chk("t6_no_early_valid", early, 0);
    tick_to(134);
    chk_out("t6_first", 1, 127, 0);

    // Asynchronous reset with a sample pending
    bus.dout_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0);
    chk("async_reset_ovr", int'(bus.overrun), 0);
    #10;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
